// File: rtl/riscv_pipe_pkg.sv
// riscv_pipe_pkg: shared pipeline definitions.
//   EXC_NONE        - exception code meaning "no exception"
//   stage_state_e   - skid stage occupancy states (value == held beat count)
//   xlen_bits()     - data word width for a 2-bit XLEN code (1 << (code+4))
//   ex_mem_t        - EX/MEM control/data bundle carried as a stage payload
//   EX_MEM_CTRL_MASK- side-effecting control bits of ex_mem_t, killed on exceptions
`ifndef XLEN_32b
`define XLEN_32b 2'd1
`endif
`ifndef XLEN_64b
`define XLEN_64b 2'd2
`endif

package riscv_pipe_pkg;

  localparam logic [3:0] EXC_NONE = 4'hF;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } stage_state_e;

  localparam logic [1:0] XLEN_32B = `XLEN_32b;
  localparam logic [1:0] XLEN_64B = `XLEN_64b;

  function automatic int unsigned xlen_bits(input logic [1:0] code);
    return 32'd1 << (32'(code) + 32'd4);
  endfunction

  // EX/MEM bundle for a 64-bit core, padded to the default 256-bit payload.
  typedef struct packed {
    logic [40:0] rsvd;
    logic [63:0] pc;
    logic [63:0] alu_result;
    logic [63:0] store_data;
    logic [11:0] csr_addr;
    logic [4:0]  rd;
    logic        mem_read;
    logic        reg_wr;
    logic        mem_write;
    logic        csr_reg_write;
    logic        store_byte;
    logic        store_half;
  } ex_mem_t;

  localparam int unsigned EX_MEM_W = $bits(ex_mem_t);

  // Bits that would commit architectural side effects downstream.
  function automatic logic [EX_MEM_W-1:0] ex_mem_ctrl_mask();
    ex_mem_t m;
    m               = '0;
    m.reg_wr        = 1'b1;
    m.mem_write     = 1'b1;
    m.csr_reg_write = 1'b1;
    m.store_byte    = 1'b1;
    m.store_half    = 1'b1;
    return m;
  endfunction

  localparam logic [EX_MEM_W-1:0] EX_MEM_CTRL_MASK = ex_mem_ctrl_mask();

endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter that sticks at all-ones.
//   i_clk   - clock
//   i_rst   - synchronous active-high clear
//   i_inc   - count enable
//   o_count - current count (registered)
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (i_inc && (count_q != {CNT_W{1'b1}})) count_d = count_q + CNT_W'(1);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) count_q <= '0;
    else       count_q <= count_d;
  end

  assign o_count = count_q;

endmodule

// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage: two-entry (HEAD + SKID) valid/ready pipeline register
// with exception masking, flush, and a saturating backpressure counter.
//   i_valid/o_ready/i_payload/i_exc_code - upstream beat
//   o_valid/i_ready/o_payload/o_exc_code - downstream head beat
//   i_flush          - drop all held beats and any beat offered this cycle
//   o_flush_upstream - combinational: an exception beat is being accepted
//   o_occupancy      - held beats (0..2)
//   o_stall_cnt      - saturating count of o_valid && !i_ready cycles
// Cores carrying ex_mem_t should set CTRL_MASK to EX_MEM_CTRL_MASK.
module pipe_skid_stage
  import riscv_pipe_pkg::*;
#(
  parameter logic [1:0]           XLEN      = `XLEN_64b,
  parameter int unsigned          PAYLOAD_W = 256,
  parameter logic [PAYLOAD_W-1:0] CTRL_MASK = {PAYLOAD_W{1'b0}},
  parameter int unsigned          CNT_W     = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [PAYLOAD_W-1:0] i_payload,
  input  logic [3:0]           i_exc_code,
  input  logic                 i_flush,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [PAYLOAD_W-1:0] o_payload,
  output logic [3:0]           o_exc_code,
  output logic                 o_flush_upstream,
  output logic [1:0]           o_occupancy,
  output logic [CNT_W-1:0]     o_stall_cnt
);

  if (!(XLEN inside {XLEN_32B, XLEN_64B})) begin : g_bad_xlen
    $error("pipe_skid_stage: unsupported XLEN code");
  end

  stage_state_e         state_q, state_d;
  logic [PAYLOAD_W-1:0] head_pay_q, head_pay_d, skid_pay_q, skid_pay_d;
  logic [3:0]           head_exc_q, head_exc_d, skid_exc_q, skid_exc_d;
  logic                 exc_pend_q, exc_pend_d;
  logic                 ready_q, ready_d;

  logic                 accept, retire, in_is_exc;
  logic [PAYLOAD_W-1:0] in_pay;

  assign in_is_exc = (i_exc_code != EXC_NONE);
  assign in_pay    = in_is_exc ? (i_payload & ~CTRL_MASK) : i_payload;
  assign accept    = i_valid && ready_q;
  assign retire    = (state_q != ST_EMPTY) && i_ready;

  // Next state. An accepted exception beat is always the youngest held
  // beat, so it is retiring exactly when it is the only one left.
  always_comb begin
    state_d    = state_q;
    head_pay_d = head_pay_q;
    head_exc_d = head_exc_q;
    skid_pay_d = skid_pay_q;
    skid_exc_d = skid_exc_q;
    exc_pend_d = exc_pend_q;
    if (i_flush) begin
      state_d    = ST_EMPTY;
      head_pay_d = '0;
      head_exc_d = EXC_NONE;
      skid_pay_d = '0;
      skid_exc_d = EXC_NONE;
      exc_pend_d = 1'b0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d    = ST_ONE;
            head_pay_d = in_pay;
            head_exc_d = i_exc_code;
            exc_pend_d = in_is_exc;
          end
        end
        ST_ONE: begin
          if (accept && !retire) begin
            state_d    = ST_FULL;
            skid_pay_d = in_pay;
            skid_exc_d = i_exc_code;
            exc_pend_d = in_is_exc;
          end else if (retire && !accept) begin
            state_d    = ST_EMPTY;
            head_pay_d = '0;
            head_exc_d = EXC_NONE;
            exc_pend_d = 1'b0;
          end else if (accept && retire) begin
            head_pay_d = in_pay;
            head_exc_d = i_exc_code;
            exc_pend_d = in_is_exc;
          end
        end
        ST_FULL: begin
          if (retire) begin
            state_d    = ST_ONE;
            head_pay_d = skid_pay_q;
            head_exc_d = skid_exc_q;
            skid_pay_d = '0;
            skid_exc_d = EXC_NONE;
          end
        end
        default: begin
          state_d    = ST_EMPTY;
          head_pay_d = '0;
          head_exc_d = EXC_NONE;
          skid_pay_d = '0;
          skid_exc_d = EXC_NONE;
          exc_pend_d = 1'b0;
        end
      endcase
    end
    ready_d = (state_d != ST_FULL) && !exc_pend_d;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_EMPTY;
      head_pay_q <= '0;
      head_exc_q <= EXC_NONE;
      skid_pay_q <= '0;
      skid_exc_q <= EXC_NONE;
      exc_pend_q <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      head_pay_q <= head_pay_d;
      head_exc_q <= head_exc_d;
      skid_pay_q <= skid_pay_d;
      skid_exc_q <= skid_exc_d;
      exc_pend_q <= exc_pend_d;
      ready_q    <= ready_d;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_inc  (o_valid && !i_ready),
    .o_count(o_stall_cnt)
  );

  // HEAD is held at 0 / EXC_NONE whenever the stage is empty.
  assign o_valid          = (state_q != ST_EMPTY);
  assign o_ready          = ready_q;
  assign o_payload        = head_pay_q;
  assign o_exc_code       = head_exc_q;
  assign o_occupancy      = 2'(state_q);
  assign o_flush_upstream = i_valid && ready_q && in_is_exc && !i_rst;

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Bench for pipe_skid_stage: directed vector table, saturation sequence,
// then random traffic against a queue-based reference model.
module tb_pipe_skid_stage;

  localparam int unsigned     PW   = 16;
  localparam logic [PW-1:0]   MASK = 16'h00F0;
  localparam int unsigned     CW   = 4;

  logic          i_clk = 1'b0;
  logic          i_rst, i_valid, i_flush, i_ready;
  logic [PW-1:0] i_payload;
  logic [3:0]    i_exc_code;
  logic          o_ready, o_valid, o_flush_upstream;
  logic [PW-1:0] o_payload;
  logic [3:0]    o_exc_code;
  logic [1:0]    o_occupancy;
  logic [CW-1:0] o_stall_cnt;

  int n_pass  = 0;
  int n_total = 0;

  always #5 i_clk = ~i_clk;

  pipe_skid_stage #(.PAYLOAD_W(PW), .CTRL_MASK(MASK), .CNT_W(CW)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_payload(i_payload), .i_exc_code(i_exc_code), .i_flush(i_flush),
    .o_valid(o_valid), .i_ready(i_ready), .o_payload(o_payload),
    .o_exc_code(o_exc_code), .o_flush_upstream(o_flush_upstream),
    .o_occupancy(o_occupancy), .o_stall_cnt(o_stall_cnt)
  );

  // ---------------- reference model: FIFO of held beats ----------------
  typedef struct { logic [PW-1:0] p; logic [3:0] e; } beat_t;
  beat_t mq[$];
  int    m_cnt = 0;

  function automatic bit m_ready();
    if (mq.size() >= 2) return 1'b0;
    foreach (mq[i]) if (mq[i].e != 4'hF) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit m_fup();
    return i_valid && m_ready() && (i_exc_code != 4'hF) && !i_rst;
  endfunction

  task automatic model_step();
    bit    acc, ret;
    beat_t b;
    if (i_rst) begin
      mq.delete();
      m_cnt = 0;
      return;
    end
    acc = i_valid && m_ready();
    ret = (mq.size() > 0) && i_ready;
    if ((mq.size() > 0) && !i_ready && (m_cnt < (2**CW - 1))) m_cnt++;
    if (i_flush) begin
      mq.delete();
      return;
    end
    if (ret) void'(mq.pop_front());
    if (acc) begin
      b.p = (i_exc_code != 4'hF) ? (i_payload & ~MASK) : i_payload;
      b.e = i_exc_code;
      mq.push_back(b);
    end
  endtask

  // ---------------- drive / check helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic drive(input logic rst, input logic v, input logic [PW-1:0] p,
                       input logic [3:0] e, input logic fl, input logic rdy);
    @(negedge i_clk);
    i_rst = rst; i_valid = v; i_payload = p; i_exc_code = e;
    i_flush = fl; i_ready = rdy;
    #1;
  endtask

  task automatic tick();
    @(posedge i_clk);
    model_step();
    #1;
  endtask

  task automatic chk_outs(input string tag, input logic ev, input logic [PW-1:0] ep,
                          input logic [3:0] ee, input logic [1:0] eo, input logic er,
                          input logic [CW-1:0] es);
    chk({tag, ".valid"}, 32'(o_valid),     32'(ev));
    chk({tag, ".pay"},   32'(o_payload),   32'(ep));
    chk({tag, ".exc"},   32'(o_exc_code),  32'(ee));
    chk({tag, ".occ"},   32'(o_occupancy), 32'(eo));
    chk({tag, ".rdy"},   32'(o_ready),     32'(er));
    chk({tag, ".stall"}, 32'(o_stall_cnt), 32'(es));
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic rst, v; logic [PW-1:0] p; logic [3:0] e; logic fl, rdy;
    logic fup;
    logic ev; logic [PW-1:0] ep; logic [3:0] ee; logic [1:0] eo; logic er;
    logic [CW-1:0] es;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(input int rst, v, p, e, fl, rdy, fup,
                              input int ev, ep, ee, eo, er, es);
    vec_t t;
    t.rst = 1'(rst); t.v = 1'(v); t.p = PW'(p); t.e = 4'(e);
    t.fl = 1'(fl); t.rdy = 1'(rdy); t.fup = 1'(fup);
    t.ev = 1'(ev); t.ep = PW'(ep); t.ee = 4'(ee); t.eo = 2'(eo);
    t.er = 1'(er); t.es = CW'(es);
    return t;
  endfunction

  logic          r_rst, r_v, r_fl, r_rdy;
  logic [PW-1:0] r_p;
  logic [3:0]    r_e;

  initial begin
    i_rst = 1'b1; i_valid = 1'b0; i_payload = '0; i_exc_code = 4'hF;
    i_flush = 1'b0; i_ready = 1'b1;

    //            rst v  pay    exc fl rdy fup | v  pay    exc occ rdy stall
    tbl.push_back(mk(1, 0, 0,     15, 0, 1,  0,   0, 0,     15, 0, 1, 0));
    for (int i = 1; i <= 8; i++)          // streaming, latency 1
      tbl.push_back(mk(0, 1, i,   15, 0, 1,  0,   1, i,     15, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0,     15, 0, 1,  0,   0, 0,     15, 0, 1, 0));
    // backpressure A, B
    tbl.push_back(mk(0, 1, 'hA,   15, 0, 0,  0,   1, 'hA,   15, 1, 1, 0));
    tbl.push_back(mk(0, 1, 'hB,   15, 0, 0,  0,   1, 'hA,   15, 2, 0, 1));
    tbl.push_back(mk(0, 0, 0,     15, 0, 0,  0,   1, 'hA,   15, 2, 0, 2));
    tbl.push_back(mk(0, 0, 0,     15, 0, 0,  0,   1, 'hA,   15, 2, 0, 3));
    tbl.push_back(mk(0, 0, 0,     15, 0, 1,  0,   1, 'hB,   15, 1, 1, 3));
    tbl.push_back(mk(0, 0, 0,     15, 0, 1,  0,   0, 0,     15, 0, 1, 3));
    // exception into empty stage; o_ready held low until it retires
    tbl.push_back(mk(0, 1, 'hFF,   2, 0, 0,  1,   1, 'h0F,   2, 1, 0, 3));
    tbl.push_back(mk(0, 1, 'h55,  15, 0, 0,  0,   1, 'h0F,   2, 1, 0, 4));
    tbl.push_back(mk(0, 0, 0,     15, 0, 1,  0,   0, 0,     15, 0, 1, 4));
    // exception behind an older beat
    tbl.push_back(mk(0, 1, 'h11,  15, 0, 0,  0,   1, 'h11,  15, 1, 1, 4));
    tbl.push_back(mk(0, 1, 'h1FF,  3, 0, 0,  1,   1, 'h11,  15, 2, 0, 5));
    tbl.push_back(mk(0, 0, 0,     15, 0, 1,  0,   1, 'h10F,  3, 1, 0, 5));
    tbl.push_back(mk(0, 1, 'h22,  15, 0, 1,  0,   0, 0,     15, 0, 1, 5));
    // flush while FULL with a beat offered
    tbl.push_back(mk(0, 1, 'h33,  15, 0, 0,  0,   1, 'h33,  15, 1, 1, 5));
    tbl.push_back(mk(0, 1, 'h44,  15, 0, 0,  0,   1, 'h33,  15, 2, 0, 6));
    tbl.push_back(mk(0, 1, 'h66,  15, 1, 1,  0,   0, 0,     15, 0, 1, 6));
    tbl.push_back(mk(0, 0, 0,     15, 0, 1,  0,   0, 0,     15, 0, 1, 6));
    // flush beats an exception capture
    tbl.push_back(mk(0, 1, 'h77,   4, 1, 1,  1,   0, 0,     15, 0, 1, 6));
    // reset while FULL, then latency-1 beat
    tbl.push_back(mk(0, 1, 'h77,  15, 0, 0,  0,   1, 'h77,  15, 1, 1, 6));
    tbl.push_back(mk(0, 1, 'h88,  15, 0, 0,  0,   1, 'h77,  15, 2, 0, 7));
    tbl.push_back(mk(1, 0, 0,     15, 0, 1,  0,   0, 0,     15, 0, 1, 0));
    tbl.push_back(mk(1, 1, 'h1,    5, 0, 1,  0,   0, 0,     15, 0, 1, 0));
    tbl.push_back(mk(0, 1, 'h99,  15, 0, 0,  0,   1, 'h99,  15, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0,     15, 0, 1,  0,   0, 0,     15, 0, 1, 0));

    foreach (tbl[k]) begin
      drive(tbl[k].rst, tbl[k].v, tbl[k].p, tbl[k].e, tbl[k].fl, tbl[k].rdy);
      chk($sformatf("vec%0d.fup", k), 32'(o_flush_upstream), 32'(tbl[k].fup));
      tick();
      chk_outs($sformatf("vec%0d", k), tbl[k].ev, tbl[k].ep, tbl[k].ee,
               tbl[k].eo, tbl[k].er, tbl[k].es);
    end

    // stall counter saturation: 20 held cycles on a 4-bit counter
    drive(1'b1, 1'b0, '0, 4'hF, 1'b0, 1'b1); tick();
    drive(1'b0, 1'b1, 16'h0005, 4'hF, 1'b0, 1'b0); tick();
    for (int k = 1; k <= 20; k++) begin
      drive(1'b0, 1'b0, '0, 4'hF, 1'b0, 1'b0); tick();
      if (k == 10) chk("sat.mid", 32'(o_stall_cnt), 32'd10);
    end
    chk_outs("sat.end", 1'b1, 16'h0005, 4'hF, 2'd1, 1'b1, 4'd15);
    drive(1'b0, 1'b0, '0, 4'hF, 1'b0, 1'b1); tick();
    chk_outs("sat.drain", 1'b0, '0, 4'hF, 2'd0, 1'b1, 4'd15);

    // random traffic against the model
    drive(1'b1, 1'b0, '0, 4'hF, 1'b0, 1'b1); tick();
    for (int c = 0; c < 400; c++) begin
      r_rst = ($urandom_range(0, 59) == 0);
      r_fl  = ($urandom_range(0, 15) == 0);
      r_v   = ($urandom_range(0, 3) != 0);
      r_rdy = ($urandom_range(0, 2) != 0);
      r_p   = PW'($urandom);
      r_e   = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 14)) : 4'hF;
      drive(r_rst, r_v, r_p, r_e, r_fl, r_rdy);
      chk($sformatf("rnd%0d.fup", c), 32'(o_flush_upstream), 32'(m_fup()));
      tick();
      chk_outs($sformatf("rnd%0d", c), mq.size() > 0,
               (mq.size() > 0) ? mq[0].p : '0,
               (mq.size() > 0) ? mq[0].e : 4'hF,
               2'(mq.size()), m_ready(), CW'(m_cnt));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pipe_skid_stage.md
PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

Interface
REQ-001 Parameter XLEN, default `XLEN_64b, 2-bit width code; data word width is 1<<(XLEN+4).
REQ-002 Parameter PAYLOAD_W, default 256; width of the opaque stage payload bundle.
REQ-003 Parameter CTRL_MASK, default {PAYLOAD_W{1'b0}}; payload bits forced to 0 on an exception beat.
REQ-004 Parameter CNT_W, default 16; stall counter width.
REQ-005 i_clk  in  1  clock; all state updates on posedge.
REQ-006 i_rst  in  1  reset, synchronous, active-high.
REQ-007 i_valid  in  1  upstream beat valid.
REQ-008 o_ready  out  1  stage can accept a beat this cycle.
REQ-009 i_payload  in  PAYLOAD_W  upstream payload.
REQ-010 i_exc_code  in  4  upstream exception code; 4'hF = none.
REQ-011 i_flush  in  1  kill all held beats, for example on a redirect.
REQ-012 o_valid  out  1  downstream beat valid.
REQ-013 i_ready  in  1  downstream accepts the beat.
REQ-014 o_payload  out  PAYLOAD_W  head-beat payload.
REQ-015 o_exc_code  out  4  head-beat exception code.
REQ-016 o_flush_upstream  out  1  request to flush the older stages.
REQ-017 o_occupancy  out  2  number of held beats, 0 to 2.
REQ-018 o_stall_cnt  out  CNT_W  saturating count of backpressure cycles.

Function
REQ-019 The stage SHALL hold two entries, HEAD and SKID.
- States: EMPTY, ONE, FULL.
- o_occupancy SHALL equal 0, 1 or 2 respectively.
REQ-020 o_ready SHALL be a registered signal, equal to (state != FULL).
REQ-021 A beat is accepted when i_valid && o_ready.
- Accepted into an empty stage, it SHALL appear on the outputs the next cycle (latency 1).
REQ-022 A beat is retired when o_valid && i_ready; o_valid SHALL equal (state != EMPTY).
REQ-023 State transitions:
- EMPTY: accept -> ONE.
- ONE: accept without retire -> FULL; retire without accept -> EMPTY; both -> ONE, HEAD <= new beat.
- FULL: retire -> ONE, HEAD <= SKID; accept is impossible because o_ready = 0.
REQ-024 Beats SHALL retire in acceptance order; no beat is duplicated or lost except by flush.
REQ-025 Exception beat handling (i_exc_code != 4'hF on an accepted beat):
- The stored payload SHALL be i_payload & ~CTRL_MASK.
- The exception code SHALL be stored with the beat.
- The beat SHALL still be delivered downstream.
REQ-026 o_flush_upstream SHALL be combinational, equal to i_valid && o_ready && (i_exc_code != 4'hF).
REQ-027 After an exception beat is accepted, o_ready SHALL be 0 until that beat retires.
REQ-028 i_flush SHALL take effect at the next edge:
- Clear both entries; state <= EMPTY.
- Drop any beat offered in the same cycle.
- Leave o_stall_cnt unchanged.
REQ-029 Event priority SHALL be: i_rst > i_flush > exception capture > normal accept/retire.
REQ-030 o_stall_cnt SHALL increment on each cycle with o_valid && !i_ready, and SHALL saturate at all-ones with no wrap.
REQ-031 o_payload and o_exc_code SHALL be 0 and 4'hF respectively while o_valid = 0.

Reset
REQ-032 On i_rst, the following SHALL be cleared at the next edge:
- state = EMPTY, o_valid = 0, o_ready = 1.
- o_payload = 0, o_exc_code = 4'hF.
- o_occupancy = 0, o_stall_cnt = 0.
REQ-033 i_rst asserted while the stage is FULL SHALL discard both beats, with no retire in that cycle.
REQ-034 o_flush_upstream SHALL be 0 while i_rst = 1.

Structure
REQ-035 The shared package riscv_pipe_pkg SHALL hold:
- EXC_NONE = 4'hF.
- The state encoding EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2.
- XLEN width helpers.
REQ-036 The saturating counter SHALL be one sub-module, sat_counter, parametrised by CNT_W.
REQ-037 The existing EX/MEM control fields SHALL map into the payload.
- reg_wr, mem_write, csr_reg_write and store_byte/half SHALL be in CTRL_MASK.

Verification
REQ-038 Streaming: i_valid = 1, i_ready = 1 for 8 cycles, payloads 1..8 -> o_payload 1..8, each 1 cycle after acceptance; o_stall_cnt = 0.
REQ-039 Backpressure: accept A = 0xA then B = 0xB with i_ready = 0:
- Response: o_occupancy = 2, o_ready = 0, o_stall_cnt increments every held cycle.
- Raise i_ready: A then B retire in order.
REQ-040 Exception: CTRL_MASK = 0xF0, payload 0xFF with i_exc_code = 4'h2:
- o_flush_upstream = 1 in the acceptance cycle.
- Next cycle: o_payload = 0x0F, o_exc_code = 4'h2.
- o_ready = 0 until that beat retires.
REQ-041 Flush while FULL, with i_valid = 1 in the same cycle -> next cycle o_valid = 0, o_occupancy = 0, o_ready = 1; the offered beat is never output.
REQ-042 Saturation: CNT_W = 4 with 20 stall cycles -> o_stall_cnt = 15.
REQ-043 Reset while FULL -> all outputs at the REQ-032 values next cycle; a subsequent beat passes with latency 1.
